vga_rx_decoder: RTL and testbench
=================================

Name: vga_rx_decoder

Overview:
Receive-side counterpart of the VGA generator: samples the Tiny VGA PMOD output byte and recovers the video stream from it. Outputs are 6-bit RrGgBb pixels, recovered x/y coordinates, a pixel-valid strobe, measured line/frame timing and a lock indicator. It sits in loopback test harnesses and on a second tile, sharing the generator's pixel clock. It has no pattern knowledge; all timing is measured from the sync edges.

Parameters:
H_BACK, 48, samples from first inactive-hsync sample to active pixel x=0
H_ACTIVE, 640, active pixels per line
V_BACK, 32, lines from line index 0 to active line y=0
V_ACTIVE, 480, active lines per frame
LOCK_FRAMES, 2, consecutive matching frames required to assert lock (1..7)

Ports:
clk  in  1  pixel clock, same domain as generator
rst_n  in  1  asynchronous active-low reset
i_pmod  in  8  PMOD byte {hsync,b0,g0,r0,vsync,b1,g1,r1}; syncs active-low
o_rgb  out  6  recovered colour, RrGgBb order
o_x  out  10  active-area pixel x
o_y  out  10  active-area line y
o_pixel_valid  out  1  o_rgb/o_x/o_y describe an active pixel
o_frame_start  out  1  one-cycle pulse when line index resets to 0
o_line_len  out  11  clocks between last two hsync trailing edges
o_frame_lines  out  11  lines in last complete frame
o_locked  out  1  timing stable

Behaviour:
- Input stage: i_pmod is registered every cycle into s_pmod, with no gating. prev_hs and prev_vs hold the previous s_pmod sync bits.
- Edges: h_edge = s_hs & ~prev_hs. v_edge = s_vs & ~prev_vs. These mark the first inactive sample after each sync pulse.
- Sample index idx (11b): h_edge -> 0; otherwise hcnt+1, saturating at 2047. hcnt <= idx each cycle.
- Line length: on h_edge, o_line_len <= hcnt+1. The first h_edge after reset or a timeout does not update it; this is tracked with a first_line flag.
- Vertical: v_edge sets vpend. On h_edge with vpend: vcnt <= 0, vpend <= 0, pulse o_frame_start, and o_frame_lines <= vcnt+1. On h_edge without vpend: vcnt <= vcnt+1, saturating at 2047.
- If v_edge and h_edge occur in the same cycle, the vpend path applies and the vcnt reset happens in that cycle.
- Output stage (registered, 2 cycles from pin to output):
  - o_rgb = {s_r1,s_r0,s_g1,s_g0,s_b1,s_b0} from the current sample.
  - hact = H_BACK <= idx < H_BACK+H_ACTIVE. vact = V_BACK <= vcnt' < V_BACK+V_ACTIVE, where vcnt' is the vcnt value in effect for the current sample.
  - o_x = idx-H_BACK and o_y = vcnt'-V_BACK, truncated to 10b. Both are 0 when the window test fails.
  - o_pixel_valid = o_locked & hact & vact.
  - o_rgb passes through regardless of validity.
- Lock FSM (state, match count mcnt 3b):
  - SEARCH: o_locked=0. Go to TRACK at the first o_frame_start. Latch ref_len = current o_line_len; mcnt=0.
  - TRACK: o_locked=0. Any h_edge whose new line length differs from ref_len sets mcnt=0 and reloads ref_len. At o_frame_start, if the frame had no mismatch and frame_lines equals the previous frame_lines, mcnt+1, otherwise mcnt=0. At mcnt==LOCK_FRAMES go to LOCKED.
  - LOCKED: o_locked=1. Any line-length mismatch or frame_lines change drops to TRACK with mcnt=0; o_locked falls the next cycle.
  - Any state: idx saturating at 2047 (hsync lost) sets SEARCH, vpend=0, first_line=1.
- Reset (asynchronous assert, synchronous release):
  - All registers are 0 and the state is SEARCH.
  - s_pmod, prev_hs and prev_vs reset to 1 (syncs inactive), so that no spurious edge occurs on release.
  - All outputs are 0.
  - Reset mid-frame discards lock. The design must relock within LOCK_FRAMES+2 frames of stable input.
- The first frame after reset is partial, so its frame_lines is never compared.

Test Plan:
- Synthetic sync, 800-clock lines, 96-clock hsync pulse, 525 lines, 2-line vsync, for 5 frames -> o_line_len=800, o_frame_lines=525. o_frame_start once per 420000 clocks. o_locked rises at the 3rd o_frame_start (after SEARCH entry, 2 matching frames).
- Locked, pins driven with an RGB pattern equal to (x+y)&63 in the active window -> every o_pixel_valid cycle has o_rgb==(o_x+o_y)&63. Exactly 640x480=307200 valid cycles per frame; o_x runs 0..639, o_y runs 0..479.
- Locked, one line shortened to 799 clocks -> o_locked falls 1 cycle after that h_edge. It reasserts after 2 subsequent clean frames.
- hsync held low for 3000 clocks -> SEARCH at idx=2047; o_locked=0; o_pixel_valid stays 0. Normal timing resumes -> relock.
- v_edge coincident with h_edge -> vcnt=0 and o_frame_start in the same frame; o_frame_lines unchanged at 525.
- rst_n pulsed low mid-line while locked -> all outputs 0 asynchronously. No o_frame_start until the first full vsync; relock within 4 frames.

Source files
------------

// File: rtl/vga_rx_decoder.sv
// Receive-side VGA decoder: samples the Tiny VGA PMOD byte, measures line/frame
// timing from the sync edges, recovers pixel coordinates and reports lock.
module vga_rx_decoder #(
   parameter int H_BACK      = 48,
   parameter int H_ACTIVE    = 640,
   parameter int V_BACK      = 32,
   parameter int V_ACTIVE    = 480,
   parameter int LOCK_FRAMES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  i_pmod,
   output logic [5:0]  o_rgb,
   output logic [9:0]  o_x,
   output logic [9:0]  o_y,
   output logic        o_pixel_valid,
   output logic        o_frame_start,
   output logic [10:0] o_line_len,
   output logic [10:0] o_frame_lines,
   output logic        o_locked
);

   typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} lock_state_e;

   localparam logic [10:0] CNT_MAX   = 11'h7FF;
   localparam logic [10:0] H_LO      = 11'(H_BACK);
   localparam logic [10:0] H_HI      = 11'(H_BACK + H_ACTIVE);
   localparam logic [10:0] V_LO      = 11'(V_BACK);
   localparam logic [10:0] V_HI      = 11'(V_BACK + V_ACTIVE);
   localparam logic [2:0]  MCNT_LOCK = 3'(LOCK_FRAMES);

   lock_state_e state_q, state_d;
   logic [7:0]  s_pmod_q;
   logic        prev_hs_q, prev_vs_q;
   logic [10:0] hcnt_q, vcnt_q, vcnt_d, ref_len_q, ref_len_d;
   logic        vpend_q, vpend_d, line_seen_q, line_seen_d;
   logic        frame_seen_q, frame_seen_d, lines_valid_q, lines_valid_d;
   logic        frame_bad_q, frame_bad_d;
   logic [2:0]  mcnt_q, mcnt_d;
   logic [5:0]  rgb_q, rgb_d;
   logic [9:0]  x_q, x_d, y_q, y_d;
   logic        valid_q, valid_d, fs_q, locked_q, locked_d;
   logic [10:0] line_len_q, line_len_d, frame_lines_q, frame_lines_d;

   logic        h_edge, v_edge, fs, lost, len_valid, len_mis, lines_mis, act;
   logic [10:0] idx, new_len, new_lines;

   // Edges mark the first inactive sample after each (active-low) sync pulse.
   assign h_edge    = s_pmod_q[7] & ~prev_hs_q;
   assign v_edge    = s_pmod_q[3] & ~prev_vs_q;
   assign idx       = h_edge ? 11'd0 : (hcnt_q == CNT_MAX) ? CNT_MAX : hcnt_q + 11'd1;
   assign lost      = (idx == CNT_MAX);
   assign new_len   = hcnt_q + 11'd1;
   assign new_lines = vcnt_q + 11'd1;
   assign fs        = h_edge & (vpend_q | v_edge);
   assign len_valid = h_edge & line_seen_q;
   assign len_mis   = len_valid & (new_len != ref_len_q);
   assign lines_mis = fs & lines_valid_q & (new_lines != frame_lines_q);

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      vcnt_d        = vcnt_q;
      vpend_d       = vpend_q;
      line_seen_d   = line_seen_q | h_edge;
      frame_seen_d  = frame_seen_q | fs;
      lines_valid_d = lines_valid_q | (fs & frame_seen_q);
      line_len_d    = len_valid ? new_len : line_len_q;
      frame_lines_d = fs ? new_lines : frame_lines_q;
      frame_bad_d   = fs ? 1'b0 : (frame_bad_q | len_mis);
      state_d       = state_q;
      mcnt_d        = mcnt_q;
      ref_len_d     = ref_len_q;

      if (fs) begin
         vcnt_d  = 11'd0;
         vpend_d = 1'b0;
      end else begin
         if (h_edge && vcnt_q != CNT_MAX) vcnt_d = vcnt_q + 11'd1;
         if (v_edge) vpend_d = 1'b1;
      end

      unique case (state_q)
         SEARCH: if (fs) begin
            state_d   = TRACK;
            ref_len_d = len_valid ? new_len : line_len_q;
            mcnt_d    = 3'd0;
         end
         TRACK: begin
            if (len_mis) begin
               ref_len_d = new_len;
               mcnt_d    = 3'd0;
            end
            // The closing line of a frame counts against that frame.
            if (fs) begin
               if (!frame_bad_q && !len_mis && !lines_mis) begin
                  mcnt_d = mcnt_q + 3'd1;
                  if (mcnt_q + 3'd1 == MCNT_LOCK) state_d = LOCKED;
               end else begin
                  mcnt_d = 3'd0;
               end
            end
         end
         LOCKED: if (len_mis || lines_mis) begin
            state_d = TRACK;
            mcnt_d  = 3'd0;
            if (len_mis) ref_len_d = new_len;
         end
         default: state_d = SEARCH;
      endcase

      // hsync lost: forget everything learned about the timing.
      if (lost) begin
         state_d       = SEARCH;
         mcnt_d        = 3'd0;
         vpend_d       = 1'b0;
         line_seen_d   = 1'b0;
         frame_seen_d  = 1'b0;
         lines_valid_d = 1'b0;
         frame_bad_d   = 1'b0;
      end

      act      = (idx >= H_LO) && (idx < H_HI) && (vcnt_d >= V_LO) && (vcnt_d < V_HI);
      x_d      = act ? 10'(idx - H_LO) : 10'd0;
      y_d      = act ? 10'(vcnt_d - V_LO) : 10'd0;
      locked_d = (state_d == LOCKED);
      valid_d  = locked_d & act;
      rgb_d    = {s_pmod_q[0], s_pmod_q[4], s_pmod_q[1], s_pmod_q[5], s_pmod_q[2], s_pmod_q[6]};
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_pmod_q      <= 8'h88;
         prev_hs_q     <= 1'b1;
         prev_vs_q     <= 1'b1;
         hcnt_q        <= '0;
         vcnt_q        <= '0;
         vpend_q       <= 1'b0;
         line_seen_q   <= 1'b0;
         frame_seen_q  <= 1'b0;
         lines_valid_q <= 1'b0;
         frame_bad_q   <= 1'b0;
         ref_len_q     <= '0;
         mcnt_q        <= '0;
         state_q       <= SEARCH;
         rgb_q         <= '0;
         x_q           <= '0;
         y_q           <= '0;
         valid_q       <= 1'b0;
         fs_q          <= 1'b0;
         locked_q      <= 1'b0;
         line_len_q    <= '0;
         frame_lines_q <= '0;
      end else begin
         s_pmod_q      <= i_pmod;
         prev_hs_q     <= s_pmod_q[7];
         prev_vs_q     <= s_pmod_q[3];
         hcnt_q        <= idx;
         vcnt_q        <= vcnt_d;
         vpend_q       <= vpend_d;
         line_seen_q   <= line_seen_d;
         frame_seen_q  <= frame_seen_d;
         lines_valid_q <= lines_valid_d;
         frame_bad_q   <= frame_bad_d;
         ref_len_q     <= ref_len_d;
         mcnt_q        <= mcnt_d;
         state_q       <= state_d;
         rgb_q         <= rgb_d;
         x_q           <= x_d;
         y_q           <= y_d;
         valid_q       <= valid_d;
         fs_q          <= fs;
         locked_q      <= locked_d;
         line_len_q    <= line_len_d;
         frame_lines_q <= frame_lines_d;
      end
   end

   assign o_rgb         = rgb_q;
   assign o_x           = x_q;
   assign o_y           = y_q;
   assign o_pixel_valid = valid_q;
   assign o_frame_start = fs_q;
   assign o_line_len    = line_len_q;
   assign o_frame_lines = frame_lines_q;
   assign o_locked      = locked_q;

endmodule

// File: tb/tb_vga_rx_decoder.sv
// Directed bench for vga_rx_decoder using a reduced video timing (40x30 frame)
// and a per-cycle scoreboard of expected colour/coordinates.
module tb_vga_rx_decoder;

   localparam int HT = 40, HS = 4, HB = 6, HA = 24;
   localparam int VT = 30, VS = 2, VB = 3, VA = 20;
   localparam int FRAME = HT * VT;

   typedef struct packed {
      logic [5:0] rgb;
      logic       act;
      logic [9:0] x;
      logic [9:0] y;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  i_pmod;
   logic [5:0]  o_rgb;
   logic [9:0]  o_x, o_y;
   logic        o_pixel_valid, o_frame_start, o_locked;
   logic [10:0] o_line_len, o_frame_lines;

   int   errors = 0, checks = 0;
   exp_t q[$];
   bit   mon_en = 1'b0;
   int   cyc = 0, fs_cnt = 0, last_fs_cyc = -1, fs_delta = 0;
   int   lock_rise_fs = 0, fall_cnt = 0, fall_len = 0;
   int   valid_cnt = 0, max_x = 0, max_y = 0, min_x = 1023, min_y = 1023;
   logic prev_locked = 1'b0;
   int   vc = 0, hc = 0, cur_len = HT;
   bit   coinc = 1'b0;

   vga_rx_decoder #(.H_BACK(HB), .H_ACTIVE(HA), .V_BACK(VB), .V_ACTIVE(VA), .LOCK_FRAMES(2)) dut (
      .clk(clk), .rst_n(rst_n), .i_pmod(i_pmod), .o_rgb(o_rgb), .o_x(o_x), .o_y(o_y),
      .o_pixel_valid(o_pixel_valid), .o_frame_start(o_frame_start),
      .o_line_len(o_line_len), .o_frame_lines(o_frame_lines), .o_locked(o_locked)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic clear_stats();
      valid_cnt = 0; max_x = 0; max_y = 0; min_x = 1023; min_y = 1023;
   endtask

   task automatic drive(input logic hs, input logic vs, input logic [5:0] rgb,
                        input logic act, input logic [9:0] x, input logic [9:0] y);
      exp_t e;
      @(posedge clk); #1;
      i_pmod = {hs, rgb[0], rgb[2], rgb[4], vs, rgb[1], rgb[3], rgb[5]};
      e.rgb = rgb; e.act = act; e.x = x; e.y = y;
      q.push_back(e);
   endtask

   task automatic gen_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         logic hs, vs, act;
         int x, y;
         logic [5:0] rgb;
         hs = (hc >= HS);
         if (coinc) vs = !((vc == 0 && hc >= HS) || (vc > 0 && vc < VS) || (vc == VS && hc < HS));
         else       vs = (vc >= VS);
         x   = hc - (HS + HB);
         y   = vc - (VS + VB);
         act = (x >= 0 && x < HA && y >= 0 && y < VA);
         rgb = act ? 6'((x + y) & 63) : 6'((hc * 5 + vc) & 63);
         drive(hs, vs, rgb, act, act ? 10'(x) : 10'd0, act ? 10'(y) : 10'd0);
         hc++;
         if (hc == cur_len) begin
            hc = 0; cur_len = HT;
            vc = (vc == VT - 1) ? 0 : vc + 1;
         end
      end
   endtask

   task automatic gen_to(input int vt, input int ht);
      do gen_cycles(1); while (!(vc == vt && hc == ht));
   endtask

   // Scoreboard: each output cycle reflects the pins driven two cycles earlier.
   always @(negedge clk) begin : monitor
      exp_t e;
      cyc++;
      if (rst_n && o_frame_start) begin
         fs_cnt++;
         if (last_fs_cyc >= 0) fs_delta = cyc - last_fs_cyc;
         last_fs_cyc = cyc;
      end
      if (o_locked && !prev_locked) lock_rise_fs = fs_cnt;
      if (!o_locked && prev_locked) begin fall_cnt++; fall_len = int'(o_line_len); end
      prev_locked = o_locked;
      if (mon_en && rst_n && q.size() >= 3) begin
         e = q.pop_front();
         checks++;
         assert (o_rgb === e.rgb) else begin
            errors++; $error("FAIL rgb: observed=%0d expected=%0d", o_rgb, e.rgb);
         end
         checks++;
         assert (o_pixel_valid === (o_locked & e.act)) else begin
            errors++; $error("FAIL valid: observed=%b expected=%b", o_pixel_valid, o_locked & e.act);
         end
         if (o_locked) begin
            checks++;
            assert ({o_x, o_y} === {e.x, e.y}) else begin
               errors++; $error("FAIL xy: observed=%0d,%0d expected=%0d,%0d", o_x, o_y, e.x, e.y);
            end
         end
         if (o_pixel_valid) begin
            valid_cnt++;
            if (int'(o_x) > max_x) max_x = int'(o_x);
            if (int'(o_y) > max_y) max_y = int'(o_y);
            if (int'(o_x) < min_x) min_x = int'(o_x);
            if (int'(o_y) < min_y) min_y = int'(o_y);
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      i_pmod = 8'hFF;
      repeat (3) @(posedge clk);
      #3;
      check("reset_outputs", {o_rgb, o_x, o_y, o_pixel_valid, o_frame_start, o_line_len, o_frame_lines, o_locked}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      q.delete();
      mon_en = 1'b1;

      // Acquisition: lock at the third frame start.
      gen_to(3, 0);
      check("fs1_count", fs_cnt, 1);
      check("fs1_locked", o_locked, 0);
      check("fs1_line_len", o_line_len, HT);
      gen_to(3, 0);
      check("fs2_count", fs_cnt, 2);
      check("fs2_locked", o_locked, 0);
      check("fs2_frame_lines", o_frame_lines, VT);
      gen_to(3, 0);
      check("fs3_locked", o_locked, 1);
      check("fs3_lock_rise", lock_rise_fs, 3);
      check("fs3_period", fs_delta, FRAME);
      for (int f = 0; f < 2; f++) begin
         clear_stats();
         gen_to(3, 0);
         check("frame_valid_cnt", valid_cnt, HA * VA);
         check("frame_max_x", max_x, HA - 1);
         check("frame_max_y", max_y, VA - 1);
         check("frame_min_xy", {min_x, min_y}, 0);
         check("frame_lines", o_frame_lines, VT);
         check("line_len", o_line_len, HT);
         check("frame_locked", o_locked, 1);
      end
      check("fs5_count", fs_cnt, 5);

      // One short line drops lock; two clean frames later it returns.
      gen_to(10, 0);
      cur_len = HT - 1;
      gen_to(12, 0);
      check("short_unlocked", o_locked, 0);
      check("short_fall_cnt", fall_cnt, 1);
      check("short_fall_len", fall_len, HT - 1);
      gen_to(3, 0);
      check("short_fs6_locked", o_locked, 0);
      gen_to(3, 0);
      check("short_fs7_locked", o_locked, 0);
      gen_to(3, 0);
      check("short_fs8_locked", o_locked, 1);
      check("short_lock_rise", lock_rise_fs, 8);
      check("short_line_len", o_line_len, HT);

      // hsync held low long enough to saturate the sample counter.
      gen_to(10, 0);
      clear_stats();
      repeat (3000) drive(1'b0, 1'b1, 6'd0, 1'b0, 10'd0, 10'd0);
      check("lost_locked", o_locked, 0);
      check("lost_fall_cnt", fall_cnt, 2);
      check("lost_no_valid", valid_cnt, 0);
      check("lost_no_fs", fs_cnt, 8);
      gen_to(3, 0);
      check("lost_fs9_locked", o_locked, 0);
      gen_to(3, 0);
      check("lost_fs10_locked", o_locked, 0);
      gen_to(3, 0);
      check("lost_fs11_locked", o_locked, 1);
      check("lost_lock_rise", lock_rise_fs, 11);

      // vsync rising on the same sample as hsync.
      coinc = 1'b1;
      gen_to(3, 0);
      check("coinc_fs12", fs_cnt, 12);
      check("coinc_period", fs_delta, FRAME);
      gen_to(3, 0);
      coinc = 1'b0;
      check("coinc_fs13", fs_cnt, 13);
      check("coinc_frame_lines", o_frame_lines, VT);
      check("coinc_locked", o_locked, 1);
      check("coinc_no_fall", fall_cnt, 2);

      // Asynchronous reset mid-line while locked.
      gen_to(12, 20);
      #2;
      mon_en = 1'b0;
      rst_n = 1'b0;
      #1;
      check("midreset_outputs", {o_rgb, o_x, o_y, o_pixel_valid, o_frame_start, o_line_len, o_frame_lines, o_locked}, 0);
      gen_cycles(3);
      #1;
      rst_n = 1'b1;
      q.delete();
      mon_en = 1'b1;
      gen_to(0, 0);
      check("midreset_no_fs", fs_cnt, 13);
      check("midreset_unlocked", o_locked, 0);
      gen_to(3, 0);
      check("midreset_fs14_locked", o_locked, 0);
      gen_to(3, 0);
      check("midreset_fs15_locked", o_locked, 0);
      gen_to(3, 0);
      check("midreset_fs16_locked", o_locked, 1);
      check("midreset_lock_rise", lock_rise_fs, 16);
      check("midreset_frame_lines", o_frame_lines, VT);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
